// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and constants for the CPU run-control unit.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StRun,
    StStep,
    StHalt
  } state_e;

  localparam logic [1:0] HC_NONE = 2'd0;
  localparam logic [1:0] HC_QUIT = 2'd1;
  localparam logic [1:0] HC_BRK  = 2'd2;
  localparam logic [1:0] HC_STEP = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Host command / pipeline status bundle for cpu_run_ctrl.
// master: host and pipeline side; slave: the run-control unit.
interface cpu_run_ctrl_if #(
  parameter int unsigned NBRK   = 4,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned BIDX_W = (NBRK > 1) ? $clog2(NBRK) : 1
);
  logic              cpu_start;
  logic              quit_cmd;
  logic              step_cmd;
  logic [STEP_W-1:0] step_cnt;
  logic              brk_set;
  logic              brk_clr;
  logic [BIDX_W-1:0] brk_idx;
  logic [29:0]       brk_adr;
  logic [29:0]       pc_id;
  logic              pc_valid_id;
  logic              stall;
  logic              stall_1shot;
  logic              stall_dly;
  logic              rst_pipe;
  logic              halted;
  logic [1:0]        halt_cause;
  logic [NBRK-1:0]   brk_hit_vec;

  modport master (
    output cpu_start, quit_cmd, step_cmd, step_cnt, brk_set, brk_clr, brk_idx, brk_adr,
           pc_id, pc_valid_id,
    input  stall, stall_1shot, stall_dly, rst_pipe, halted, halt_cause, brk_hit_vec
  );

  modport slave (
    input  cpu_start, quit_cmd, step_cmd, step_cnt, brk_set, brk_clr, brk_idx, brk_adr,
           pc_id, pc_valid_id,
    output stall, stall_1shot, stall_dly, rst_pipe, halted, halt_cause, brk_hit_vec
  );

endinterface

// File: rtl/cpu_brk_match.sv
// PC breakpoint channels: armed/address registers with set/clear and parallel comparators.
module cpu_brk_match #(
  parameter int unsigned NBRK   = 4,
  parameter int unsigned BIDX_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_i,
  input  logic              clr_i,
  input  logic [BIDX_W-1:0] idx_i,
  input  logic [29:0]       adr_i,
  input  logic [29:0]       pc_i,
  input  logic              pc_valid_i,
  input  logic              skip_i,
  output logic [NBRK-1:0]   hit_o
);

  logic [NBRK-1:0]       armed_q, armed_d;
  logic [NBRK-1:0][29:0] adr_q, adr_d;

  // Clear beats set when both target the same channel.
  always_comb begin
    armed_d = armed_q;
    adr_d   = adr_q;
    for (int unsigned i = 0; i < NBRK; i++) begin
      if (idx_i == BIDX_W'(i)) begin
        if (clr_i) begin
          armed_d[i] = 1'b0;
        end else if (set_i) begin
          armed_d[i] = 1'b1;
          adr_d[i]   = adr_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed_q <= '0;
      adr_q   <= '0;
    end else begin
      armed_q <= armed_d;
      adr_q   <= adr_d;
    end
  end

  always_comb begin
    hit_o = '0;
    for (int unsigned i = 0; i < NBRK; i++) begin
      hit_o[i] = armed_q[i] & pc_valid_i & ~skip_i & (adr_q[i] == pc_i);
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run-control unit: start/flush, N-step, halt/resume and pipeline stall strobes.
// Breakpoint channels are built only when CPU_RUN_CTRL_BRK_EN is defined.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int unsigned NBRK   = 4,
  parameter int unsigned STEP_W = 16,
  parameter int unsigned BIDX_W = (NBRK > 1) ? $clog2(NBRK) : 1
) (
  input logic           clk,
  input logic           rst,
  cpu_run_ctrl_if.slave bus
);

  state_e            state_q, state_d;
  state_e            next_q, next_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [1:0]        cause_q, cause_d;
  logic [NBRK-1:0]   hit_q, hit_d;
  logic              stall_dly_q;

  logic [NBRK-1:0]   brk_hit;
  logic              running;
  logic              brk_any;
  logic              stall;
  logic              adv;
  logic              resume_brk;
  logic              step_ok;

  assign running = (state_q == StRun) || (state_q == StStep);
  // A match holds the instruction in ID in the same cycle it is seen.
  assign brk_any = running & (|brk_hit);
  assign stall   = ~running | brk_any;
  assign adv     = bus.pc_valid_id & ~stall;
  assign step_ok = bus.step_cmd & (bus.step_cnt != '0);

  always_comb begin
    state_d    = state_q;
    next_d     = next_q;
    cnt_d      = cnt_q;
    cause_d    = cause_q;
    hit_d      = hit_q;
    resume_brk = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.cpu_start) begin
          state_d = StFlush;
          next_d  = StRun;
          cause_d = HC_NONE;
          hit_d   = '0;
        end else if (step_ok) begin
          state_d = StFlush;
          next_d  = StStep;
          cnt_d   = bus.step_cnt;
          cause_d = HC_NONE;
          hit_d   = '0;
        end
      end
      StFlush: state_d = next_q;
      StRun, StStep: begin
        if ((state_q == StStep) && adv) begin
          cnt_d = cnt_q - STEP_W'(1);
        end
        if (bus.quit_cmd) begin
          state_d = StIdle;
          cause_d = HC_QUIT;
        end else if (brk_any) begin
          state_d = StHalt;
          cause_d = HC_BRK;
          hit_d   = brk_hit;
        end else if ((state_q == StStep) && adv && (cnt_q == STEP_W'(1))) begin
          state_d = StHalt;
          cause_d = HC_STEP;
        end
      end
      StHalt: begin
        if (bus.quit_cmd) begin
          state_d = StIdle;
          cause_d = HC_QUIT;
        end else if (bus.cpu_start) begin
          state_d    = StRun;
          cause_d    = HC_NONE;
          hit_d      = '0;
          resume_brk = (cause_q == HC_BRK);
        end else if (step_ok) begin
          state_d    = StStep;
          cnt_d      = bus.step_cnt;
          cause_d    = HC_NONE;
          hit_d      = '0;
          resume_brk = (cause_q == HC_BRK);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      next_q      <= StRun;
      cnt_q       <= '0;
      cause_q     <= HC_NONE;
      hit_q       <= '0;
      stall_dly_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      cnt_q       <= cnt_d;
      cause_q     <= cause_d;
      hit_q       <= hit_d;
      stall_dly_q <= stall;
    end
  end

`ifdef CPU_RUN_CTRL_BRK_EN
  logic skip_q;

  cpu_brk_match #(
    .NBRK   (NBRK),
    .BIDX_W (BIDX_W)
  ) u_brk_match (
    .clk_i      (clk),
    .rst_i      (rst),
    .set_i      (bus.brk_set),
    .clr_i      (bus.brk_clr),
    .idx_i      (bus.brk_idx),
    .adr_i      (bus.brk_adr),
    .pc_i       (bus.pc_id),
    .pc_valid_i (bus.pc_valid_id),
    .skip_i     (skip_q),
    .hit_o      (brk_hit)
  );

  // Lets the trapped instruction retire once after resume instead of re-trapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip_q <= 1'b0;
    end else if (resume_brk) begin
      skip_q <= 1'b1;
    end else if (adv) begin
      skip_q <= 1'b0;
    end
  end
`else
  logic unused_brk;

  assign brk_hit    = '0;
  assign unused_brk = ^{bus.brk_set, bus.brk_clr, bus.brk_idx, bus.brk_adr, bus.pc_id,
                        resume_brk};
`endif

  assign bus.stall       = stall;
  assign bus.stall_dly   = stall_dly_q;
  assign bus.stall_1shot = stall & ~stall_dly_q;
  assign bus.rst_pipe    = (state_q == StFlush);
  assign bus.halted      = (state_q == StIdle) || (state_q == StHalt);
  assign bus.halt_cause  = cause_q;
  assign bus.brk_hit_vec = hit_q;

endmodule
